clk_interval_timer: RTL and testbench
=====================================

// Module: clk_interval_timer
// PURPOSE
//  Parametrised timebase: free-running tick and seconds counters plus a PPS strobe from one clock.
//  Extends the fixed microsecond/second counter with a configurable tick rate and a loadable seconds count.
//  Adds optional discipline to an external PPS input, measurement of the external PPS interval,
//  and loss-of-PPS detection. Feeds timestamping and housekeeping logic across the EVG.
// PARAMETERS
//  CLK_RATE     100000000  clk frequency in Hz; clocks per second; must be >= 4
//  TICK_RATE    1000000    ticksSinceBoot rate in Hz; must divide CLK_RATE exactly; DIV = CLK_RATE/TICK_RATE
//  WIDTH        32         width of ticksSinceBoot, secondsSinceBoot, secondsLoadValue, lastIntervalClocks
//  PPS_WIDTH    1          PPS output high time in clk cycles; range 1..CLK_RATE-1
//  SYNC_STAGES  2          synchroniser flops on ppsIn; must be >= 2
// PORTS
//  clk                 in   1                  single clock; all logic on rising edge
//  rst_n               in   1                  reset, asynchronous, active-low
//  ppsIn               in   1                  external PPS, asynchronous to clk, rising edge is significant
//  syncEnable          in   1                  1: discipline second boundary to ppsIn
//  secondsLoadStrobe   in   1                  one-cycle strobe: load secondsLoadValue
//  secondsLoadValue    in   WIDTH              value loaded into secondsSinceBoot
//  ticksSinceBoot      out  WIDTH              ticks since reset, wraps mod 2^WIDTH
//  secondsSinceBoot    out  WIDTH              seconds count, wraps mod 2^WIDTH
//  subSecondCount      out  $clog2(CLK_RATE)   clocks into current second, 0..CLK_RATE-1
//  PPS                 out  1                  high PPS_WIDTH cycles starting at each second rollover
//  lastIntervalClocks  out  WIDTH              clk cycles between the last two synchronised ppsIn edges
//  ppsInMissing        out  1                  no ppsIn edge for 2*CLK_RATE cycles while syncEnable
// BEHAVIOUR
//  Reset: every output and internal counter is 0 while rst_n is low. Any operation in progress, including PPS high, is abandoned.
//  Rollover: subSecondCount == CLK_RATE-1 -> next cycle subSecondCount = 0 and secondsSinceBoot += 1.
//   PPS rises on that same cycle and stays high PPS_WIDTH cycles. A new rollover while PPS is high restarts the width count.
//  Ticks: divider counts 0..DIV-1. On wrap, ticksSinceBoot += 1. The divider is independent of second rollover except on resync.
//  Load: secondsLoadStrobe -> secondsSinceBoot = secondsLoadValue next cycle. Load beats a coincident increment (no +1).
//   subSecondCount, ticks and PPS are unaffected by a load.
//  ppsIn path: SYNC_STAGES flops, then a rising-edge detect.
//   Edge pulse appears SYNC_STAGES+1 cycles after the ppsIn rise.
//  Interval meter, always active: a counter increments every cycle and saturates at 2^WIDTH-1.
//   On an edge pulse, lastIntervalClocks = counter+1 and the counter clears to 0.
//   The first edge after reset also loads lastIntervalClocks, with the count since reset.
//  Resync, when syncEnable=1 and an edge pulse arrives:
//   next cycle subSecondCount = 0, tick divider = 0, and PPS rises.
//   secondsSinceBoot += 1 only if subSecondCount >= CLK_RATE/2 (early edge).
//   Late edge (subSecondCount < CLK_RATE/2, a rollover already counted): no increment, no double count.
//   Edge on the same cycle as a natural rollover: exactly one increment and one PPS.
//   Edge plus load on the same cycle: load wins.
//   With syncEnable=0, edge pulses only update the interval meter.
//  Missing: ppsInMissing sets when syncEnable=1 and the interval counter reaches 2*CLK_RATE.
//   It clears on the next edge pulse or when syncEnable=0. Free-running continues while missing.
//  Arithmetic: all counters unsigned and wrap mod 2^WIDTH, except the saturating interval counter. No overflow flags.
// TESTING
//  Bench settings: CLK_RATE=100, TICK_RATE=10, PPS_WIDTH=3, WIDTH=32, unless stated.
//  1 Free-run after reset -> ticksSinceBoot +1 every 10 clks.
//    secondsSinceBoot 0->1 exactly 100 clks after reset release; PPS high 3 clks; repeats every 100.
//  2 Load 0x12345678 on the rollover cycle -> seconds=0x12345678, then 0x12345679 100 clks later.
//    Load 0xFFFFFFFF -> next rollover gives 0.
//  3 syncEnable=1, ppsIn rising every 103 clks -> lastIntervalClocks=103.
//    Seconds +1 per 103-clk period, never +2; PPS at natural wrap and at resync.
//  4 syncEnable=1, ppsIn every 97 clks -> lastIntervalClocks=97, seconds +1 per edge.
//    Natural rollover never reached; subSecondCount=0 SYNC_STAGES+2 clks after each ppsIn rise.
//  5 Stop ppsIn -> ppsInMissing rises 200 clks after last edge pulse.
//    Seconds keep +1/100 clks; next edge clears ppsInMissing.
//  6 Assert rst_n low mid-PPS with seconds=5 -> all outputs 0 immediately.
//    After release, first rollover at 100 clks.

Source files
------------

// File: rtl/clk_interval_timer_if.sv
// Timebase bus: PPS input, discipline/load controls and every timebase output.
// The timer takes the slave view; the logic that drives ppsIn and the controls takes the master view.
interface clk_interval_timer_if #(
    parameter int WIDTH    = 32,
    parameter int CLK_RATE = 100000000
);
    localparam int SS_W = $clog2(CLK_RATE);

    logic             ppsIn;
    logic             syncEnable;
    logic             secondsLoadStrobe;
    logic [WIDTH-1:0] secondsLoadValue;
    logic [WIDTH-1:0] ticksSinceBoot;
    logic [WIDTH-1:0] secondsSinceBoot;
    logic [SS_W-1:0]  subSecondCount;
    logic             PPS;
    logic [WIDTH-1:0] lastIntervalClocks;
    logic             ppsInMissing;

    modport master (
        output ppsIn, syncEnable, secondsLoadStrobe, secondsLoadValue,
        input  ticksSinceBoot, secondsSinceBoot, subSecondCount, PPS,
        input  lastIntervalClocks, ppsInMissing
    );

    modport slave (
        input  ppsIn, syncEnable, secondsLoadStrobe, secondsLoadValue,
        output ticksSinceBoot, secondsSinceBoot, subSecondCount, PPS,
        output lastIntervalClocks, ppsInMissing
    );
endinterface

// File: rtl/clk_interval_timer.sv
// Timebase: tick and seconds counters, PPS strobe, optional discipline to an external PPS,
// measurement of the external PPS interval and loss-of-PPS detection.
module clk_interval_timer #(
    parameter int CLK_RATE    = 100000000,
    parameter int TICK_RATE   = 1000000,
    parameter int WIDTH       = 32,
    parameter int PPS_WIDTH   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    clk_interval_timer_if.slave   bus
);
    localparam int SS_W  = $clog2(CLK_RATE);
    localparam int DIV   = CLK_RATE / TICK_RATE;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PW_W  = $clog2(PPS_WIDTH + 1);

    localparam logic [SS_W-1:0]  SUB_LAST   = SS_W'(CLK_RATE - 1);
    localparam logic [SS_W-1:0]  SUB_HALF   = SS_W'(CLK_RATE / 2);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);
    localparam logic [PW_W-1:0]  PPS_LOAD   = PW_W'(PPS_WIDTH);
    localparam logic [WIDTH-1:0] MISS_LIMIT = WIDTH'(64'(CLK_RATE) * 2);
    localparam logic [WIDTH-1:0] CNT_MAX    = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   syncPrev_q;
    logic                   edge_q;

    logic [SS_W-1:0]  subSecond_q,   subSecond_d;
    logic [DIV_W-1:0] div_q,         div_d;
    logic [WIDTH-1:0] ticks_q,       ticks_d;
    logic [WIDTH-1:0] seconds_q,     seconds_d;
    logic [PW_W-1:0]  ppsCnt_q,      ppsCnt_d;
    logic [WIDTH-1:0] intervalCnt_q, intervalCnt_d;
    logic [WIDTH-1:0] lastInterval_q, lastInterval_d;
    logic             missing_q,     missing_d;

    logic naturalRoll;
    logic resync;
    logic divWrap;

    // Synchronise ppsIn and register a one-cycle pulse on its rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            syncPrev_q <= 1'b0;
            edge_q     <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], bus.ppsIn};
            syncPrev_q <= sync_q[SYNC_STAGES-1];
            edge_q     <= sync_q[SYNC_STAGES-1] & ~syncPrev_q;
        end
    end

    // Next-state for the counters: a resync restarts the second and the tick divider, and only
    // counts a second when the edge arrives in the second half (otherwise the rollover already did).
    always_comb begin
        naturalRoll = (subSecond_q == SUB_LAST);
        resync      = bus.syncEnable && edge_q;
        divWrap     = (div_q == DIV_LAST);

        subSecond_d = subSecond_q + 1'b1;
        if (naturalRoll || resync) begin
            subSecond_d = '0;
        end

        div_d = div_q + 1'b1;
        if (divWrap || resync) begin
            div_d = '0;
        end

        ticks_d = divWrap ? ticks_q + 1'b1 : ticks_q;

        seconds_d = seconds_q;
        if (bus.secondsLoadStrobe) begin
            seconds_d = bus.secondsLoadValue;
        end else if (naturalRoll || (resync && (subSecond_q >= SUB_HALF))) begin
            seconds_d = seconds_q + 1'b1;
        end

        ppsCnt_d = ppsCnt_q;
        if (naturalRoll || resync) begin
            ppsCnt_d = PPS_LOAD;
        end else if (ppsCnt_q != '0) begin
            ppsCnt_d = ppsCnt_q - 1'b1;
        end

        lastInterval_d = lastInterval_q;
        intervalCnt_d  = (intervalCnt_q == CNT_MAX) ? CNT_MAX : intervalCnt_q + 1'b1;
        if (edge_q) begin
            lastInterval_d = intervalCnt_d;
            intervalCnt_d  = '0;
        end

        missing_d = bus.syncEnable && (intervalCnt_d >= MISS_LIMIT);
    end

    // Counter and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            subSecond_q    <= '0;
            div_q          <= '0;
            ticks_q        <= '0;
            seconds_q      <= '0;
            ppsCnt_q       <= '0;
            intervalCnt_q  <= '0;
            lastInterval_q <= '0;
            missing_q      <= 1'b0;
        end else begin
            subSecond_q    <= subSecond_d;
            div_q          <= div_d;
            ticks_q        <= ticks_d;
            seconds_q      <= seconds_d;
            ppsCnt_q       <= ppsCnt_d;
            intervalCnt_q  <= intervalCnt_d;
            lastInterval_q <= lastInterval_d;
            missing_q      <= missing_d;
        end
    end

    assign bus.ticksSinceBoot     = ticks_q;
    assign bus.secondsSinceBoot   = seconds_q;
    assign bus.subSecondCount     = subSecond_q;
    assign bus.PPS                = (ppsCnt_q != '0);
    assign bus.lastIntervalClocks = lastInterval_q;
    assign bus.ppsInMissing       = missing_q;
endmodule

// File: tb/tb_clk_interval_timer.sv
// Bench for clk_interval_timer: event-based timebase model compared every cycle, plus literal pins.
module tb_clk_interval_timer;
    localparam int CLK_RATE    = 100;
    localparam int TICK_RATE   = 10;
    localparam int WIDTH       = 32;
    localparam int PPS_WIDTH   = 3;
    localparam int SYNC_STAGES = 2;
    localparam int DIV         = CLK_RATE / TICK_RATE;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int assertCount = 0;
    int failCount   = 0;

    clk_interval_timer_if #(.WIDTH(WIDTH), .CLK_RATE(CLK_RATE)) bus ();

    clk_interval_timer #(
        .CLK_RATE(CLK_RATE), .TICK_RATE(TICK_RATE), .WIDTH(WIDTH),
        .PPS_WIDTH(PPS_WIDTH), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Model state: n counts clock edges since reset release; second and tick phases are
    // described by the edge at which they last restarted.
    int          n;
    int          anchor;
    int          divAnchor;
    int unsigned ticksBase;
    int unsigned mSeconds;
    int          lastBoundary;
    int          lastPulse;
    int unsigned mLastInterval;
    bit          mMissing;
    bit          hist[$];
    int unsigned mTicks;
    int          mSub;
    bit          mPps;

    function automatic bit histAt(int k);
        if (k < 0 || k >= hist.size()) return 1'b0;
        return hist[k];
    endfunction

    task automatic modelDerive();
        mSub   = (n - anchor) % CLK_RATE;
        mTicks = ticksBase + int'((n - divAnchor) / DIV);
        mPps   = (n - lastBoundary) < PPS_WIDTH;
    endtask

    task automatic modelReset();
        n             = 0;
        anchor        = 0;
        divAnchor     = 0;
        ticksBase     = 0;
        mSeconds      = 0;
        lastBoundary  = -1000000;
        lastPulse     = 0;
        mLastInterval = 0;
        mMissing      = 1'b0;
        hist.delete();
        hist.push_back(1'b0);
        modelDerive();
    endtask

    task automatic modelStep();
        bit pulse;
        bit natural;
        bit resync;
        int prevSub;
        n++;
        hist.push_back(bus.ppsIn);
        pulse   = histAt(n - 1 - SYNC_STAGES) && !histAt(n - 2 - SYNC_STAGES);
        prevSub = (n - 1 - anchor) % CLK_RATE;
        natural = ((n - anchor) % CLK_RATE) == 0;
        resync  = bus.syncEnable && pulse;
        if (bus.secondsLoadStrobe) mSeconds = bus.secondsLoadValue;
        else if (natural || (resync && prevSub >= CLK_RATE / 2)) mSeconds = mSeconds + 1;
        if (natural || resync) lastBoundary = n;
        if (resync) begin
            ticksBase = ticksBase + int'((n - divAnchor) / DIV);
            divAnchor = n;
            anchor    = n;
        end
        if (pulse) begin
            mLastInterval = n - lastPulse;
            lastPulse     = n;
        end
        mMissing = bus.syncEnable && ((n - lastPulse) >= 2 * CLK_RATE);
        modelDerive();
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic waitCycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    // One ppsIn period starting with a rise now; optionally pins the resync and a coincident load.
    task automatic applyStimulus(input int period, input bit checkResync, input bit doLoad);
        int high;
        logic [WIDTH-1:0] val;
        high = SYNC_STAGES + 2 + int'($urandom_range(1, 20));
        val  = $urandom;
        bus.ppsIn = 1'b1;
        waitCycles(SYNC_STAGES + 1);
        if (doLoad) begin
            bus.secondsLoadStrobe = 1'b1;
            bus.secondsLoadValue  = val;
        end
        waitCycles(1);
        bus.secondsLoadStrobe = 1'b0;
        if (checkResync) begin
            checkOutput("resyncSubZero", bus.subSecondCount, 0);
            checkOutput("resyncPps", bus.PPS, 1);
        end
        if (doLoad) checkOutput("loadBeatsResync", bus.secondsSinceBoot, val);
        waitCycles(high - (SYNC_STAGES + 2));
        bus.ppsIn = 1'b0;
        waitCycles(period - high);
    endtask

    // Model follows the clock and resets immediately with rst_n.
    initial begin
        modelReset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) modelReset();
            else modelStep();
        end
    end

    // Every cycle, all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            checkOutput("ticks", bus.ticksSinceBoot, mTicks);
            checkOutput("seconds", bus.secondsSinceBoot, mSeconds);
            checkOutput("subSecond", bus.subSecondCount, mSub);
            checkOutput("pps", bus.PPS, mPps);
            checkOutput("lastInterval", bus.lastIntervalClocks, mLastInterval);
            checkOutput("missing", bus.ppsInMissing, mMissing);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int found;
        bus.ppsIn             = 1'b0;
        bus.syncEnable        = 1'b0;
        bus.secondsLoadStrobe = 1'b0;
        bus.secondsLoadValue  = '0;

        // Reset state and free-running counters.
        waitCycles(3);
        checkOutput("resetTicks", bus.ticksSinceBoot, 0);
        checkOutput("resetSeconds", bus.secondsSinceBoot, 0);
        rst_n = 1'b1;
        waitCycles(9);
        checkOutput("ticksAt9", bus.ticksSinceBoot, 0);
        waitCycles(1);
        checkOutput("ticksAt10", bus.ticksSinceBoot, 1);
        waitCycles(89);
        checkOutput("subAt99", bus.subSecondCount, 99);
        checkOutput("secondsAt99", bus.secondsSinceBoot, 0);
        waitCycles(1);
        checkOutput("secondsAt100", bus.secondsSinceBoot, 1);
        checkOutput("ppsAt100", bus.PPS, 1);
        waitCycles(2);
        checkOutput("ppsAt102", bus.PPS, 1);
        waitCycles(1);
        checkOutput("ppsAt103", bus.PPS, 0);

        // Loads: on the rollover edge, wrap from all-ones, then random.
        waitCycles(96);
        bus.secondsLoadStrobe = 1'b1;
        bus.secondsLoadValue  = 32'h12345678;
        waitCycles(1);
        bus.secondsLoadStrobe = 1'b0;
        checkOutput("loadOnRollover", bus.secondsSinceBoot, 32'h12345678);
        waitCycles(100);
        checkOutput("afterLoadRollover", bus.secondsSinceBoot, 32'h12345679);
        waitCycles(49);
        bus.secondsLoadStrobe = 1'b1;
        bus.secondsLoadValue  = 32'hFFFFFFFF;
        waitCycles(1);
        bus.secondsLoadStrobe = 1'b0;
        checkOutput("loadAllOnes", bus.secondsSinceBoot, 32'hFFFFFFFF);
        waitCycles(50);
        checkOutput("wrapToZero", bus.secondsSinceBoot, 0);
        repeat (10) begin
            waitCycles(int'($urandom_range(1, 40)));
            bus.secondsLoadStrobe = 1'b1;
            bus.secondsLoadValue  = $urandom;
            waitCycles(1);
            bus.secondsLoadStrobe = 1'b0;
        end

        // Disciplined to slow and fast external PPS.
        bus.syncEnable = 1'b1;
        repeat (6) applyStimulus(103, 1'b1, 1'b0);
        checkOutput("interval103", bus.lastIntervalClocks, 103);
        repeat (6) applyStimulus(97, 1'b1, 1'b0);
        checkOutput("interval97", bus.lastIntervalClocks, 97);

        // Random periods, discipline on/off, loads coincident with resync.
        repeat (15) begin
            bus.syncEnable = 1'($urandom_range(0, 1));
            applyStimulus(int'($urandom_range(60, 140)), bus.syncEnable, 1'($urandom_range(0, 1)));
        end

        // Loss of PPS: set after 200 clocks, cleared by the next edge or by disabling discipline.
        bus.syncEnable = 1'b1;
        bus.ppsIn = 1'b1;
        waitCycles(SYNC_STAGES + 2);
        bus.ppsIn = 1'b0;
        waitCycles(199);
        checkOutput("missingAt199", bus.ppsInMissing, 0);
        waitCycles(1);
        checkOutput("missingAt200", bus.ppsInMissing, 1);
        waitCycles(150);
        bus.ppsIn = 1'b1;
        waitCycles(SYNC_STAGES + 2);
        checkOutput("missingCleared", bus.ppsInMissing, 0);
        checkOutput("interval354", bus.lastIntervalClocks, 354);
        bus.ppsIn = 1'b0;
        waitCycles(210);
        checkOutput("missingAgain", bus.ppsInMissing, 1);
        bus.syncEnable = 1'b0;
        waitCycles(1);
        checkOutput("missingDisabled", bus.ppsInMissing, 0);

        // Reset in the middle of a PPS pulse with seconds = 5.
        found = 0;
        for (int i = 0; i < 2 * CLK_RATE && found == 0; i++) begin
            waitCycles(1);
            if (bus.PPS === 1'b1) found = 1;
        end
        checkOutput("ppsSeenBeforeReset", found, 1);
        bus.secondsLoadStrobe = 1'b1;
        bus.secondsLoadValue  = 5;
        waitCycles(1);
        bus.secondsLoadStrobe = 1'b0;
        checkOutput("secondsFive", bus.secondsSinceBoot, 5);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstTicks", bus.ticksSinceBoot, 0);
        checkOutput("rstSeconds", bus.secondsSinceBoot, 0);
        checkOutput("rstSub", bus.subSecondCount, 0);
        checkOutput("rstPps", bus.PPS, 0);
        checkOutput("rstInterval", bus.lastIntervalClocks, 0);
        checkOutput("rstMissing", bus.ppsInMissing, 0);
        waitCycles(3);
        rst_n = 1'b1;
        waitCycles(99);
        checkOutput("postRstSeconds99", bus.secondsSinceBoot, 0);
        waitCycles(1);
        checkOutput("postRstSeconds100", bus.secondsSinceBoot, 1);
        checkOutput("postRstPps100", bus.PPS, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
